// File: rtl/serial_borrow_sub_pkg.sv
// Shared definitions for the bit-serial borrow subtractor.
//   DEFAULT_WIDTH : default operand/result width
//   state_e       : FSM state encoding (IDLE, RUN, DONE)
package serial_borrow_sub_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/serial_borrow_sub_fs_df.sv
// Dataflow full-subtractor cell: diff = a - b - bin for one bit position.
// Ports:
//   a    in  1  minuend bit
//   b    in  1  subtrahend bit
//   bin  in  1  borrow in
//   diff out 1  difference bit
//   bout out 1  borrow out
module fs_df (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = a ^ b ^ bin;
    // Borrow when a=0,b=1, or when a==b and a borrow is already pending.
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_borrow_sub.sv
// Bit-serial ripple-borrow subtractor, LSB first, one bit per clock.
// A single full-subtractor cell is reused across WIDTH cycles.
// Ports:
//   clk   in  1      rising-edge clock
//   rst   in  1      asynchronous active-high reset
//   start in  1      request, sampled only while busy==0
//   a     in  WIDTH  minuend, captured on accepted start
//   b     in  WIDTH  subtrahend, captured on accepted start
//   bin   in  1      borrow-in, captured on accepted start
//   busy  out 1      high while bits are being processed
//   done  out 1      one-cycle pulse, results valid
//   diff  out WIDTH  a-b-bin mod 2^WIDTH, held until the next result
//   bout  out 1      borrow-out (unsigned a < b+bin)
//   ovf   out 1      signed overflow of a-b-bin
module serial_borrow_sub
    import serial_borrow_sub_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] d_sh_q, d_sh_d;
    logic             brw_q, brw_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;

    logic cell_d;
    logic cell_bo;

    fs_df u_cell (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .bin  (brw_q),
        .diff (cell_d),
        .bout (cell_bo)
    );

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        d_sh_d  = d_sh_q;
        brw_d   = brw_q;
        cnt_d   = cnt_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;

        case (state_q)
            // DONE accepts a new start just like IDLE, giving back-to-back operation.
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    d_sh_d  = '0;
                    brw_d   = bin;
                    cnt_d   = '0;
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
                d_sh_d = {cell_d, d_sh_q[WIDTH-1:1]};
                brw_d  = cell_bo;
                cnt_d  = cnt_q + CntW'(1);
                if (cnt_q == CntLast) begin
                    state_d = ST_DONE;
                    // Load results from the final cell output so they are valid with done.
                    diff_d  = {cell_d, d_sh_q[WIDTH-1:1]};
                    bout_d  = cell_bo;
                    ovf_d   = (a_msb_q ^ b_msb_q) & (cell_d ^ a_msb_q);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            d_sh_q  <= '0;
            brw_q   <= 1'b0;
            cnt_q   <= '0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            d_sh_q  <= d_sh_d;
            brw_q   <= brw_d;
            cnt_q   <= cnt_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign diff = diff_q;
    assign bout = bout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_borrow_sub.sv
module tb_serial_borrow_sub;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;

    int checks   = 0;
    int failures = 0;

    serial_borrow_sub #(
        .WIDTH (W)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for done; returns number of negedges waited.
    task automatic wait_done(output int cycles);
        cycles = 0;
        while (done !== 1'b1 && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    // Issue one op, check latency, results and single-cycle done pulse.
    task automatic run_op(input string tag, input logic [W-1:0] ia, input logic [W-1:0] ib,
                          input logic ibin, input logic [W-1:0] ediff, input logic ebout,
                          input logic eovf);
        int cyc;
        @(negedge clk);
        a = ia; b = ib; bin = ibin; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = ~ia; b = ~ib; bin = ~ibin;  // operands are free to change after acceptance
        wait_done(cyc);
        chk({tag, "_lat"}, cyc, W);
        chk({tag, "_diff"}, diff, ediff);
        chk({tag, "_bout"}, bout, ebout);
        chk({tag, "_ovf"}, ovf, eovf);
        @(negedge clk);
        chk({tag, "_pulse"}, done, 0);
        chk({tag, "_hold"}, diff, ediff);
    endtask

    initial begin
        int cyc;
        int sa, sb, sr;
        logic [W:0] model;
        logic       movf;
        logic       seen_done;

        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_diff", diff, 0);
        chk("rst_flags", {bout, ovf}, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        run_op("t1", 4'd7, 4'd3, 1'b0, 4'h4, 1'b0, 1'b0);
        run_op("t2", 4'd3, 4'd7, 1'b0, 4'hC, 1'b1, 1'b0);
        run_op("t3a", 4'd0, 4'd0, 1'b1, 4'hF, 1'b1, 1'b0);
        run_op("t3b", 4'd5, 4'd5, 1'b0, 4'h0, 1'b0, 1'b0);
        run_op("t4a", 4'd8, 4'd1, 1'b0, 4'h7, 1'b0, 1'b1);
        run_op("t4b", 4'd7, 4'hF, 1'b0, 4'h8, 1'b1, 1'b1);

        // Start during RUN is ignored; start on the DONE cycle is accepted.
        @(negedge clk);
        a = 4'd7; b = 4'd3; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        a = 4'd1; b = 4'd2; bin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc);
        chk("t5_lat", cyc, W - 3);
        chk("t5_diff", diff, 4'h4);
        chk("t5_bout", bout, 0);
        a = 4'd9; b = 4'd2; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t5_b2b_busy", busy, 1);
        chk("t5_b2b_diffhold", diff, 4'h4);
        wait_done(cyc);
        chk("t5_b2b_lat", cyc, W);
        chk("t5_b2b_diff", diff, 4'h7);
        chk("t5_b2b_bout", bout, 0);
        chk("t5_b2b_ovf", ovf, 1);

        // Asynchronous reset mid-operation.
        @(negedge clk);
        a = 4'd3; b = 4'd7; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);
        chk("t6_diff", diff, 0);
        chk("t6_flags", {bout, ovf}, 0);
        @(negedge clk);
        rst = 1'b0;
        seen_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen_done = 1'b1;
        end
        chk("t6_no_done", seen_done, 0);
        run_op("t6_after", 4'd6, 4'd2, 1'b1, 4'h3, 1'b0, 1'b0);

        // Exhaustive sweep against an arithmetic model.
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    model = {1'b0, 4'(ia)} - {1'b0, 4'(ib)} - 5'(ic);
                    sa = (ia > 7) ? ia - 16 : ia;
                    sb = (ib > 7) ? ib - 16 : ib;
                    sr = sa - sb - ic;
                    movf = (sr < -8 || sr > 7);
                    run_op("sweep", 4'(ia), 4'(ib), 1'(ic), model[W-1:0], model[W], movf);
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
